instr_encoder: RTL
==================

# instr_encoder

Encodes RV32I instruction fields (op[6:2] class, funct3, funct7 bit 30, register indices, 32-bit immediate) into 32-bit instruction words, buffers them in a small FIFO, and streams them out with sequential word addresses to an instruction-memory write port. It is the inverse of the control unit's decoding. It is used by the test/boot loader path to build programs for the core.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2
- BASE_ADDR, 32'h0000_0000, address of the first word after reset or flush

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; empties the FIFO, rewinds the address, clears err
- in_valid  in  1  field bundle valid
- in_ready  out  1  encoder can accept this cycle
- in_op  in  5  opcode[6:2]; same encoding as control unit
- in_funct3  in  3  funct3
- in_funct7_6  in  1  instruction bit 30 (SUB/SRA/SRAI)
- in_rd, in_rs1, in_rs2  in  5 each  register indices
- in_imm  in  32  sign-extended immediate, byte-offset form
- out_valid  out  1  head word valid
- out_ready  in  1  consumer accepts head word
- out_instr  out  32  encoded word at FIFO head
- out_addr  out  32  byte address of out_instr
- count  out  $clog2(DEPTH)+1  occupancy
- err  out  1  sticky; set by an illegal in_op

## Operation
- Accept: in_valid & in_ready. Encode combinationally, then write the FIFO tail. opcode[1:0] = 2'b11 always.
- R (01100): {1'b0, funct7_6, 5'b0, rs2, rs1, funct3, rd, op, 11}.
- I-arith (00100):
  - funct3 = 001 or 101: imm field = {1'b0, funct7_6, 5'b0, in_imm[4:0]}.
  - Otherwise: in_imm[11:0].
- Load (00000): I format, in_imm[11:0].
- JALR (11001): I format with funct3 forced to 000.
- S (01000): {imm[11:5], rs2, rs1, funct3, imm[4:0], op, 11}.
- B (11000): {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op, 11}. in_imm[0] is ignored.
- LUI (01101) / AUIPC (00101): {imm[31:12], rd, op, 11}.
- JAL (11011): {imm[20], imm[10:1], imm[11], imm[19:12], rd, op, 11}. in_imm[0] is ignored.
- Fields absent from a format are not driven from the inputs; those bits take format-defined values only.
- Any other in_op:
  - The bundle is consumed (handshake completes) but nothing is pushed.
  - err is set to 1 the next cycle and holds until rst or flush.
- Pop: out_valid & out_ready. The head advances and out_addr increments by 4, wrapping modulo 2^32.
- in_ready = (count != DEPTH). There is no same-cycle pass-through when full, even if a pop occurs.
- out_valid = (count != 0).
- Simultaneous push and pop: count is unchanged, and both pointers advance, wrapping at DEPTH.
- flush has priority over push and pop in the same cycle. The accepted bundle is dropped, count → 0, out_addr → BASE_ADDR, and err → 0.

## Timing
- Reset (async assert, sync release): count = 0, out_valid = 0, in_ready = 1, out_instr = 0, out_addr = BASE_ADDR, err = 0, pointers = 0.
- Latency: a push at edge N gives out_valid = 1 and out_instr = word after edge N. Minimum 1 cycle input → output.
- out_instr and out_addr are stable while out_valid & !out_ready.
- Throughput: 1 word/cycle when out_ready is held high.
- Full:
  - The cycle after the DEPTH-th push without a pop, in_ready = 0.
  - in_ready returns to 1 the cycle after the first pop.
- Empty: out_instr holds its last value (don't-care) while out_valid = 0.
- rst asserted mid-stream discards all contents immediately, without waiting for a clock edge.

## Test plan
- ADDI x1,x0,5 (op 00100, f3 000, rd 1, imm 5), out_ready = 1 → one cycle later out_instr = 0x00500093, out_addr = 0x0.
- Back-to-back stream, one bundle per cycle:
  - SUB x3,x1,x2 (f7_6 = 1) → 0x402081B3 @0x0
  - SW x2,8(x1) → 0x0020A423 @0x4
  - BEQ x1,x2,-4 → 0xFE208EE3 @0x8
  - JAL x1,8 → 0x008000EF @0xC
  - Expect no bubbles.
- SRAI x1,x1,3 (f3 101, f7_6 = 1, in_imm = 0xFFFFFFE3) → 0x4030D093. LUI x5,0x12345 (in_imm = 0x12345000) → 0x123452B7.
- Backpressure:
  - out_ready = 0; offer 5 bundles → in_ready drops after the 4th, count = 4, and the head is held stable.
  - Raise out_ready → 4 words drain in order, with addresses incrementing by 4.
- Illegal in_op = 11111 → handshake completes, count unchanged, err = 1 next cycle. A following legal bundle still encodes correctly.
- With 3 words queued at out_addr 0x8, assert flush together with in_valid and out_ready → count = 0, out_addr = 0x0, err = 0, and neither the pushed nor the popped word appears. Async rst mid-stream gives the same result immediately.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I field-bundle encoder feeding a small FIFO that streams words with
// sequential byte addresses to an instruction-memory write port.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_op,
  input  logic [2:0]                 in_funct3,
  input  logic                       in_funct7_6,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs1,
  input  logic [4:0]                 in_rs2,
  input  logic [31:0]                in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_addr,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [4:0] OP_R     = 5'b01100;
  localparam logic [4:0] OP_IARI  = 5'b00100;
  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_JALR  = 5'b11001;
  localparam logic [4:0] OP_S     = 5'b01000;
  localparam logic [4:0] OP_B     = 5'b11000;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b11011;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [31:0]   enc_word;
  logic          enc_legal;
  logic [11:0]   imm_i;
  logic          accept, push, pop;

  // Shift-immediate ops carry funct7 bit 30 in the upper immediate bits.
  always_comb begin
    if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
      imm_i = {1'b0, in_funct7_6, 5'b0, in_imm[4:0]};
    else
      imm_i = in_imm[11:0];
  end

  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (in_op)
      OP_R:     enc_word = {1'b0, in_funct7_6, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, in_op, 2'b11};
      OP_IARI:  enc_word = {imm_i, in_rs1, in_funct3, in_rd, in_op, 2'b11};
      OP_LOAD:  enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_op, 2'b11};
      OP_JALR:  enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, in_op, 2'b11};
      OP_S:     enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_op, 2'b11};
      OP_B:     enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], in_op, 2'b11};
      OP_LUI,
      OP_AUIPC: enc_word = {in_imm[31:12], in_rd, in_op, 2'b11};
      OP_JAL:   enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_op, 2'b11};
      default:  enc_legal = 1'b0;
    endcase
  end

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign out_instr = mem[rd_ptr];

  // Illegal bundles still complete the handshake; they just never reach the FIFO.
  assign accept = in_valid & in_ready & ~flush;
  assign push   = accept & enc_legal;
  assign pop    = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      out_addr <= BASE_ADDR;
      err      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      out_addr <= BASE_ADDR;
      err      <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= enc_word;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + AW'(1);
        out_addr <= out_addr + 32'd4;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (accept && !enc_legal) err <= 1'b1;
    end
  end
endmodule
